// File: rtl/msg_cmd_scheduler.sv
// Assembles '#'-terminated UART frames, decodes IFM fault / PBM pick messages and
// issues one command at a time over valid/ready, with pending faults ahead of queued picks.
module msg_cmd_scheduler #(
  parameter int MAX_LEN    = 12,
  parameter int PICK_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_msg,
  input  logic                          rx_complete,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [1:0]                    cmd_type,
  output logic [1:0]                    cmd_unit,
  output logic [1:0]                    cmd_loc,
  output logic [2:0]                    fault_pending,
  output logic [$clog2(PICK_DEPTH):0]   pick_level,
  output logic [ERR_W-1:0]              frame_err_cnt,
  output logic [ERR_W-1:0]              pick_drop_cnt
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int PTR_W = $clog2(PICK_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // Only the longest valid frame (PBM, 11 bytes) needs its contents kept; longer
  // frames are rejected on length alone.
  localparam int STORE = 11;
  localparam logic [7:0] HASH = 8'h23;

  typedef enum logic [1:0] {COLLECT, DECODE, DISCARD} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   index_reg, index_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               buf_we;
  logic [IDX_W-1:0]   buf_widx;
  logic               discard_entry;
  logic [7:0]         fb [STORE];

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
      index_reg <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      len_reg   <= len_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    index_next    = index_reg;
    len_next      = len_reg;
    buf_we        = 1'b0;
    buf_widx      = index_reg;
    discard_entry = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (rx_complete) begin
          buf_we = 1'b1;
          if (rx_msg == HASH) begin
            len_next   = LEN_W'(index_reg) + LEN_W'(1);
            index_next = '0;
            state_next = DECODE;
          end else if (index_reg == IDX_W'(MAX_LEN - 1)) begin
            index_next    = '0;
            state_next    = DISCARD;
            discard_entry = 1'b1;
          end else begin
            index_next = index_reg + IDX_W'(1);
          end
        end
      end
      DECODE: begin
        // A byte arriving here starts the next frame; a bare '#' decodes again.
        index_next = '0;
        buf_widx   = '0;
        state_next = COLLECT;
        if (rx_complete) begin
          buf_we = 1'b1;
          if (rx_msg == HASH) begin
            len_next   = LEN_W'(1);
            state_next = DECODE;
          end else begin
            index_next = IDX_W'(1);
          end
        end
      end
      DISCARD: begin
        index_next = '0;
        if (rx_complete && rx_msg == HASH) state_next = COLLECT;
      end
      default: begin
        index_next = '0;
        state_next = COLLECT;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < STORE; gi++) begin : gen_byte
      logic [7:0] byte_reg;
      always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
          byte_reg <= '0;
        else if (buf_we && buf_widx == IDX_W'(gi))
          byte_reg <= rx_msg;
      end
      assign fb[gi] = byte_reg;
    end
  endgenerate

  logic       ifm_ok, pbm_ok;
  logic [2:0] unit_oh;

  always_comb begin
    unit_oh = 3'b000;
    case (fb[4])
      "E":     unit_oh = 3'b001;
      "C":     unit_oh = 3'b010;
      "R":     unit_oh = 3'b100;
      default: unit_oh = 3'b000;
    endcase
    ifm_ok = (len_reg == LEN_W'(8)) && ({fb[0], fb[1], fb[2], fb[3]} == "IFM-") &&
             ({fb[5], fb[6], fb[7]} == "U-#") && (unit_oh != 3'b000);
    pbm_ok = (len_reg == LEN_W'(11)) &&
             ({fb[0], fb[1], fb[2], fb[3], fb[4], fb[5], fb[6], fb[7]} == "PBM-SU-B") &&
             (fb[8] >= "1") && (fb[8] <= "4") && ({fb[9], fb[10]} == "-#");
  end

  logic [2:0] dec_fault_reg;
  logic       dec_pick_reg;
  logic [1:0] dec_loc_reg;
  logic       dec_err_reg;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      dec_fault_reg <= '0;
      dec_pick_reg  <= 1'b0;
      dec_loc_reg   <= '0;
      dec_err_reg   <= 1'b0;
    end else if (state_reg == DECODE) begin
      dec_fault_reg <= ifm_ok ? unit_oh : 3'b000;
      dec_pick_reg  <= pbm_ok;
      dec_loc_reg   <= fb[8][1:0] - 2'd1;
      dec_err_reg   <= !(ifm_ok || pbm_ok);
    end else begin
      dec_fault_reg <= '0;
      dec_pick_reg  <= 1'b0;
      dec_err_reg   <= 1'b0;
    end
  end

  logic [1:0]       fifo_mem [PICK_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [2:0]       pending_reg;
  logic             valid_reg;
  logic [1:0]       type_reg, unit_reg, loc_reg;
  logic [ERR_W-1:0] err_reg, drop_reg;

  logic             pick_full, push, drop, load, pop;
  logic [2:0]       clr;
  logic             valid_next;
  logic [1:0]       type_next, unit_next, loc_next;
  logic [ERR_W:0]   err_sum, drop_sum;

  assign pick_full = (level_reg == LVL_W'(PICK_DEPTH));
  assign push      = dec_pick_reg && !pick_full;
  assign drop      = dec_pick_reg && pick_full;
  assign load      = !valid_reg || cmd_ready;

  always_comb begin
    clr        = 3'b000;
    pop        = 1'b0;
    valid_next = valid_reg;
    type_next  = type_reg;
    unit_next  = unit_reg;
    loc_next   = loc_reg;
    if (load) begin
      valid_next = 1'b0;
      type_next  = 2'd0;
      unit_next  = 2'd0;
      loc_next   = 2'd0;
      if (pending_reg[0]) begin
        clr = 3'b001; valid_next = 1'b1; type_next = 2'd1; unit_next = 2'd0;
      end else if (pending_reg[1]) begin
        clr = 3'b010; valid_next = 1'b1; type_next = 2'd1; unit_next = 2'd1;
      end else if (pending_reg[2]) begin
        clr = 3'b100; valid_next = 1'b1; type_next = 2'd1; unit_next = 2'd2;
      end else if (level_reg != '0) begin
        pop = 1'b1; valid_next = 1'b1; type_next = 2'd2; loc_next = fifo_mem[rd_ptr_reg];
      end
    end
    err_sum  = {1'b0, err_reg} + (ERR_W+1)'(dec_err_reg) + (ERR_W+1)'(discard_entry);
    drop_sum = {1'b0, drop_reg} + (ERR_W+1)'(drop);
  end

  always_ff @(posedge clk_50M) begin
    if (push) fifo_mem[wr_ptr_reg] <= dec_loc_reg;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      pending_reg <= '0;
      valid_reg   <= 1'b0;
      type_reg    <= '0;
      unit_reg    <= '0;
      loc_reg     <= '0;
      err_reg     <= '0;
      drop_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg   <= level_reg + LVL_W'(push) - LVL_W'(pop);
      // A fault decoded in the same cycle it is issued stays pending.
      pending_reg <= (pending_reg & ~clr) | dec_fault_reg;
      valid_reg   <= valid_next;
      type_reg    <= type_next;
      unit_reg    <= unit_next;
      loc_reg     <= loc_next;
      err_reg     <= err_sum[ERR_W]  ? '1 : err_sum[ERR_W-1:0];
      drop_reg    <= drop_sum[ERR_W] ? '1 : drop_sum[ERR_W-1:0];
    end
  end

  assign cmd_valid     = valid_reg;
  assign cmd_type      = type_reg;
  assign cmd_unit      = unit_reg;
  assign cmd_loc       = loc_reg;
  assign fault_pending = pending_reg;
  assign pick_level    = level_reg;
  assign frame_err_cnt = err_reg;
  assign pick_drop_cnt = drop_reg;

endmodule

// File: tb/tb_msg_cmd_scheduler.sv
// Directed bench for msg_cmd_scheduler: frame decode, issue priority, FIFO limits,
// error counting and asynchronous reset, with hand-computed expectations.
module tb_msg_cmd_scheduler;
  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_type, cmd_unit, cmd_loc;
  logic [2:0] fault_pending;
  logic [2:0] pick_level;
  logic [7:0] frame_err_cnt, pick_drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  msg_cmd_scheduler dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .rx_msg(rx_msg), .rx_complete(rx_complete),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_unit(cmd_unit),
    .cmd_loc(cmd_loc), .fault_pending(fault_pending), .pick_level(pick_level),
    .frame_err_cnt(frame_err_cnt), .pick_drop_cnt(pick_drop_cnt)
  );

  always #5 clk_50M = ~clk_50M;

  wire [6:0] cmd_bus = {cmd_valid, cmd_type, cmd_unit, cmd_loc};

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_50M);
  endtask

  // Bytes go out on consecutive cycles; returns at the negedge after the last byte is sampled.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk_50M);
      rx_msg      = s[i];
      rx_complete = 1'b1;
    end
    @(negedge clk_50M);
    rx_complete = 1'b0;
    $display("tx frame \"%s\" (%0d bytes)", s, s.len());
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_ready = 1'b0; rx_msg = 8'h00; rx_complete = 1'b0;
    step(2);
    vectors++;
    if (cmd_bus !== 7'd0 || fault_pending !== 3'd0 || pick_level !== 3'd0 ||
        frame_err_cnt !== 8'd0 || pick_drop_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: cmd=%h pend=%b lvl=%0d err=%0d drop=%0d, want all 0",
               cmd_bus, fault_pending, pick_level, frame_err_cnt, pick_drop_cnt);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_ifm_issue;
    cmd_ready = 1'b1;
    send_str("IFM-EU-#");
    step(2);
    vectors++;
    if (fault_pending !== 3'b001 || cmd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ifm_pending: pend=%b valid=%b, want 001/0", fault_pending, cmd_valid);
    end
    step(1);
    vectors++;
    if (cmd_bus !== {1'b1, 2'd1, 2'd0, 2'd0} || fault_pending !== 3'b000) begin
      miscompares++;
      $display("FAIL ifm_issue: cmd=%b pend=%b, want 1010000/000", cmd_bus, fault_pending);
    end
    step(1);
    vectors++;
    if (cmd_bus !== 7'd0) begin
      miscompares++;
      $display("FAIL ifm_one_cycle: cmd=%b, want 0000000", cmd_bus);
    end
  endtask

  task automatic test_pick_hold;
    int bad;
    cmd_ready = 1'b0;
    send_str("PBM-SU-B3-#");
    step(2);
    vectors++;
    if (pick_level !== 3'd1 || cmd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pick_queued: lvl=%0d valid=%b, want 1/0", pick_level, cmd_valid);
    end
    step(1);
    vectors++;
    if (cmd_bus !== {1'b1, 2'd2, 2'd0, 2'd2} || pick_level !== 3'd0) begin
      miscompares++;
      $display("FAIL pick_load: cmd=%b lvl=%0d, want 1100010/0", cmd_bus, pick_level);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (cmd_bus !== {1'b1, 2'd2, 2'd0, 2'd2}) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL pick_hold: %0d of 20 cycles changed, want 0", bad);
    end
    cmd_ready = 1'b1;
    step(1);
    vectors++;
    if (cmd_bus !== 7'd0 || pick_level !== 3'd0) begin
      miscompares++;
      $display("FAIL pick_release: cmd=%b lvl=%0d, want 0/0", cmd_bus, pick_level);
    end
  endtask

  task automatic test_fifo_full;
    logic [1:0] exp_loc [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    cmd_ready = 1'b0;
    send_str("PBM-SU-B1-#");
    send_str("PBM-SU-B2-#");
    send_str("PBM-SU-B3-#");
    send_str("PBM-SU-B4-#");
    send_str("PBM-SU-B1-#");
    step(3);
    vectors++;
    if (pick_level !== 3'd4 || pick_drop_cnt !== 8'd0 || cmd_bus !== {1'b1, 2'd2, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL fifo_fill: lvl=%0d drop=%0d cmd=%b, want 4/0/1100000",
               pick_level, pick_drop_cnt, cmd_bus);
    end
    send_str("PBM-SU-B4-#");
    step(3);
    vectors++;
    if (pick_level !== 3'd4 || pick_drop_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL fifo_drop: lvl=%0d drop=%0d, want 4/1", pick_level, pick_drop_cnt);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (cmd_bus !== {1'b1, 2'd2, 2'd0, exp_loc[i]}) begin
        miscompares++;
        $display("FAIL fifo_order[%0d]: cmd=%b, want valid pick loc %0d", i, cmd_bus, exp_loc[i]);
      end
      step(1);
    end
    vectors++;
    if (cmd_bus !== 7'd0 || pick_level !== 3'd0) begin
      miscompares++;
      $display("FAIL fifo_drained: cmd=%b lvl=%0d, want 0/0", cmd_bus, pick_level);
    end
  endtask

  task automatic test_fault_priority;
    logic [6:0] exp_seq [5];
    exp_seq[0] = {1'b1, 2'd2, 2'd0, 2'd1};
    exp_seq[1] = {1'b1, 2'd1, 2'd1, 2'd0};
    exp_seq[2] = {1'b1, 2'd1, 2'd2, 2'd0};
    exp_seq[3] = {1'b1, 2'd2, 2'd0, 2'd2};
    exp_seq[4] = {1'b1, 2'd2, 2'd0, 2'd3};
    cmd_ready = 1'b0;
    send_str("PBM-SU-B2-#");
    send_str("PBM-SU-B3-#");
    send_str("PBM-SU-B4-#");
    send_str("IFM-RU-#");
    send_str("IFM-CU-#");
    step(3);
    vectors++;
    if (fault_pending !== 3'b110 || pick_level !== 3'd2) begin
      miscompares++;
      $display("FAIL prio_queued: pend=%b lvl=%0d, want 110/2", fault_pending, pick_level);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (cmd_bus !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL prio_order[%0d]: cmd=%b, want %b", i, cmd_bus, exp_seq[i]);
      end
      step(1);
    end
    vectors++;
    if (cmd_bus !== 7'd0 || fault_pending !== 3'b000) begin
      miscompares++;
      $display("FAIL prio_drained: cmd=%b pend=%b, want 0/000", cmd_bus, fault_pending);
    end
  endtask

  task automatic test_frame_errors;
    cmd_ready = 1'b1;
    send_str("AAAAAAAAAAAAA#");
    step(3);
    vectors++;
    if (frame_err_cnt !== 8'd1 || cmd_bus !== 7'd0) begin
      miscompares++;
      $display("FAIL err_oversize: err=%0d cmd=%b, want 1/0", frame_err_cnt, cmd_bus);
    end
    send_str("IFM-XU-#");
    step(3);
    vectors++;
    if (frame_err_cnt !== 8'd2 || cmd_bus !== 7'd0 || fault_pending !== 3'b000) begin
      miscompares++;
      $display("FAIL err_bad_unit: err=%0d cmd=%b pend=%b, want 2/0/000",
               frame_err_cnt, cmd_bus, fault_pending);
    end
    send_str("#");
    step(3);
    vectors++;
    if (frame_err_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL err_bare_hash: err=%0d, want 3", frame_err_cnt);
    end
    send_str("PBM-SU-B1--#");
    step(3);
    vectors++;
    if (frame_err_cnt !== 8'd4 || pick_level !== 3'd0 || cmd_bus !== 7'd0) begin
      miscompares++;
      $display("FAIL err_len12: err=%0d lvl=%0d cmd=%b, want 4/0/0",
               frame_err_cnt, pick_level, cmd_bus);
    end
  endtask

  task automatic test_back_to_back;
    cmd_ready = 1'b0;
    send_str("IFM-CU-#IFM-EU-#");
    step(3);
    vectors++;
    if (cmd_bus !== {1'b1, 2'd1, 2'd1, 2'd0} || fault_pending !== 3'b001) begin
      miscompares++;
      $display("FAIL b2b_first: cmd=%b pend=%b, want 1010100/001", cmd_bus, fault_pending);
    end
    cmd_ready = 1'b1;
    step(1);
    vectors++;
    if (cmd_bus !== {1'b1, 2'd1, 2'd0, 2'd0} || fault_pending !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b_second: cmd=%b pend=%b, want 1010000/000", cmd_bus, fault_pending);
    end
    step(1);
    vectors++;
    if (cmd_bus !== 7'd0 || frame_err_cnt !== 8'd4) begin
      miscompares++;
      $display("FAIL b2b_idle: cmd=%b err=%0d, want 0/4", cmd_bus, frame_err_cnt);
    end
  endtask

  task automatic test_async_reset;
    cmd_ready = 1'b1;
    send_str("PBM-SU-B");
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (cmd_bus !== 7'd0 || fault_pending !== 3'd0 || pick_level !== 3'd0 ||
        frame_err_cnt !== 8'd0 || pick_drop_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset: cmd=%b pend=%b lvl=%0d err=%0d drop=%0d, want all 0",
               cmd_bus, fault_pending, pick_level, frame_err_cnt, pick_drop_cnt);
    end
    step(1);
    rst_n = 1'b1;
    send_str("IFM-EU-#");
    step(2);
    vectors++;
    if (fault_pending !== 3'b001) begin
      miscompares++;
      $display("FAIL rst_frame_pending: pend=%b, want 001", fault_pending);
    end
    step(1);
    vectors++;
    if (cmd_bus !== {1'b1, 2'd1, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL rst_frame_issue: cmd=%b, want 1010000", cmd_bus);
    end
    step(1);
    vectors++;
    if (cmd_bus !== 7'd0 || frame_err_cnt !== 8'd0 || pick_drop_cnt !== 8'd0 || pick_level !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_after: cmd=%b err=%0d drop=%0d lvl=%0d, want all 0",
               cmd_bus, frame_err_cnt, pick_drop_cnt, pick_level);
    end
  endtask

  initial begin
    test_reset();
    test_ifm_issue();
    test_pick_hold();
    test_fifo_full();
    test_fault_priority();
    test_frame_errors();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
